// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter
//   Shares one single-port main memory between the instruction-fetch and the
//   data load/store requesters. Arbitrates, drives the memory strobes, waits
//   for mem_done, then returns the result with a one-cycle ack. Out-of-range
//   addresses and a missing mem_done (timeout) are reported through *_err.
//
// Ports
//   clk, reset                  clock; asynchronous active-low reset
//   if_req/if_addr              fetch request (held until if_ack)
//   if_ack/if_rdata/if_err      fetch completion pulse, data, error flag
//   d_req/d_we/d_addr/d_wdata   data request (held until d_ack)
//   d_ack/d_rdata/d_err         data completion pulse, load data, error flag
//   mem_addr/mem_wdata          memory address / write data
//   mem_write/mem_read          memory strobes
//   mem_instr                   1 = instruction memory, 0 = data memory
//   mem_rdata/mem_done          memory read data / completion flag
//   busy                        an access is in flight
module mem_access_arbiter #(
    parameter int unsigned AW           = 13,
    parameter int unsigned DW           = 13,
    parameter int unsigned DEPTH        = 13,
    parameter int unsigned TIMEOUT      = 15,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    output logic          if_err,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          d_err,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_write,
    output logic          mem_read,
    output logic          mem_instr,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_done,
    output logic          busy
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t        state_q, state_n;
    logic          gnt_if_q, gnt_if_n;
    logic [TW-1:0] timer_q, timer_n;
    logic [SW-1:0] streak_q, streak_n;

    logic          if_ack_n, if_err_n, d_ack_n, d_err_n;
    logic [DW-1:0] if_rdata_n, d_rdata_n, mem_wdata_n;
    logic [AW-1:0] mem_addr_n;
    logic          mem_write_n, mem_read_n, mem_instr_n, busy_n;
    logic          pick_if, pick_d, if_in_range, d_in_range;

    assign if_in_range = 32'(if_addr) < DEPTH;
    assign d_in_range  = 32'(d_addr) < DEPTH;

    always_comb begin
        state_n     = state_q;
        gnt_if_n    = gnt_if_q;
        timer_n     = timer_q;
        streak_n    = streak_q;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        mem_write_n = mem_write;
        mem_read_n  = mem_read;
        mem_instr_n = mem_instr;
        if_ack_n    = 1'b0;
        if_err_n    = 1'b0;
        if_rdata_n  = '0;
        d_ack_n     = 1'b0;
        d_err_n     = 1'b0;
        d_rdata_n   = '0;
        pick_if     = 1'b0;
        pick_d      = 1'b0;

        if (!if_req)
            streak_n = '0;

        case (state_q)
            ST_IDLE: begin
                // An ack cycle is a turnaround: the acked requester's req is
                // stale, and holding off both keeps the data/fetch streak
                // count meaningful when both requesters stream.
                if (!(if_ack || d_ack)) begin
                    if (if_req && (!d_req || streak_q == SW'(STARVE_LIMIT)))
                        pick_if = 1'b1;
                    else if (d_req)
                        pick_d = 1'b1;
                end

                if (pick_if) begin
                    streak_n = '0;
                    gnt_if_n = 1'b1;
                    if (if_in_range) begin
                        mem_addr_n  = if_addr;
                        mem_wdata_n = '0;
                        mem_instr_n = 1'b1;
                        mem_write_n = 1'b0;
                        mem_read_n  = 1'b1;
                        timer_n     = '0;
                        state_n     = ST_WAIT;
                    end else begin
                        if_ack_n = 1'b1;
                        if_err_n = 1'b1;
                    end
                end

                if (pick_d) begin
                    if (if_req)
                        streak_n = streak_q + 1'b1;
                    gnt_if_n = 1'b0;
                    if (d_in_range) begin
                        mem_addr_n  = d_addr;
                        mem_wdata_n = d_wdata;
                        mem_instr_n = 1'b0;
                        mem_write_n = d_we;
                        mem_read_n  = !d_we;
                        timer_n     = '0;
                        state_n     = ST_WAIT;
                    end else begin
                        d_ack_n = 1'b1;
                        d_err_n = 1'b1;
                    end
                end
            end

            ST_WAIT: begin
                if (mem_done) begin
                    mem_write_n = 1'b0;
                    mem_read_n  = 1'b0;
                    state_n     = ST_IDLE;
                    if (gnt_if_q) begin
                        if_ack_n   = 1'b1;
                        if_rdata_n = mem_rdata;
                    end else begin
                        d_ack_n   = 1'b1;
                        d_rdata_n = mem_write ? '0 : mem_rdata;
                    end
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    mem_write_n = 1'b0;
                    mem_read_n  = 1'b0;
                    state_n     = ST_IDLE;
                    if (gnt_if_q) begin
                        if_ack_n = 1'b1;
                        if_err_n = 1'b1;
                    end else begin
                        d_ack_n = 1'b1;
                        d_err_n = 1'b1;
                    end
                end else begin
                    timer_n = timer_q + 1'b1;
                end
            end

            default: state_n = ST_IDLE;
        endcase

        busy_n = (state_n == ST_WAIT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            gnt_if_q  <= 1'b0;
            timer_q   <= '0;
            streak_q  <= '0;
            if_ack    <= 1'b0;
            if_err    <= 1'b0;
            if_rdata  <= '0;
            d_ack     <= 1'b0;
            d_err     <= 1'b0;
            d_rdata   <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_write <= 1'b0;
            mem_read  <= 1'b0;
            mem_instr <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_n;
            gnt_if_q  <= gnt_if_n;
            timer_q   <= timer_n;
            streak_q  <= streak_n;
            if_ack    <= if_ack_n;
            if_err    <= if_err_n;
            if_rdata  <= if_rdata_n;
            d_ack     <= d_ack_n;
            d_err     <= d_err_n;
            d_rdata   <= d_rdata_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
            mem_write <= mem_write_n;
            mem_read  <= mem_read_n;
            mem_instr <= mem_instr_n;
            busy      <= busy_n;
        end
    end

endmodule

// File: tb/tb_mem_access_arbiter.sv
module tb_mem_access_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, d_req, d_we;
    logic [12:0] if_addr, d_addr, d_wdata;
    logic        if_ack, if_err, d_ack, d_err;
    logic [12:0] if_rdata, d_rdata;
    logic [12:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_write, mem_read, mem_instr, mem_done, busy;
    logic        model_done, spur_done, mem_en;
    logic [59:0] all_outs;

    always #5 clk = ~clk;

    mem_access_arbiter #(
        .AW(13), .DW(13), .DEPTH(13), .TIMEOUT(15), .STARVE_LIMIT(3)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
        .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
        .mem_read(mem_read), .mem_instr(mem_instr), .mem_rdata(mem_rdata),
        .mem_done(mem_done), .busy(busy)
    );

    assign mem_done = model_done | spur_done;
    assign all_outs = {if_ack, if_rdata, if_err, d_ack, d_rdata, d_err, mem_addr,
                       mem_wdata, mem_write, mem_read, mem_instr, busy};

    // Memory model: acts on the negedge after strobes appear, done cleared
    // just after the following posedge.
    logic [12:0] imem [0:12];
    logic [12:0] dmem [0:12];
    int          wr_count = 0;

    always @(negedge clk) begin
        if (mem_en && (mem_read || mem_write) && mem_addr < 13) begin
            if (mem_write) begin
                if (mem_instr) imem[mem_addr] = mem_wdata;
                else           dmem[mem_addr] = mem_wdata;
                wr_count++;
                mem_rdata = '0;
            end else begin
                mem_rdata = mem_instr ? imem[mem_addr] : dmem[mem_addr];
            end
            model_done = 1'b1;
        end
    end

    always @(posedge clk) begin
        #1 model_done = 1'b0;
    end

    // Scoreboard
    typedef struct {
        bit          fetch;
        bit          err;
        logic [12:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && (if_ack || d_ack)) begin
            exp_t e;
            vectors++;
            if (if_ack && d_ack) begin
                miscompares++;
                $display("FAIL both_acks: if_ack=1 d_ack=1 expected one");
            end else if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_ack: if_ack=%0b d_ack=%0b expected none", if_ack, d_ack);
            end else begin
                e = sb.pop_front();
                if (e.fetch != if_ack ||
                    (if_ack && (if_err != e.err || if_rdata != e.rdata)) ||
                    (d_ack  && (d_err  != e.err || d_rdata  != e.rdata))) begin
                    miscompares++;
                    $display("FAIL ack_resp: got fetch=%0b err=%0b rdata=%0h expected fetch=%0b err=%0b rdata=%0h",
                             if_ack, if_ack ? if_err : d_err, if_ack ? if_rdata : d_rdata,
                             e.fetch, e.err, e.rdata);
                end
            end
        end
    end

    // One access; called at a negedge. snap holds the strobes seen one cycle later.
    task automatic access(input bit fetch, input bit we, input logic [12:0] addr,
                          input logic [12:0] wdata, input bit exp_err,
                          input logic [12:0] exp_rdata, output int lat,
                          output logic [15:0] snap);
        sb.push_back('{fetch: fetch, err: exp_err, rdata: exp_rdata});
        if (fetch) begin
            if_addr = addr; if_req = 1'b1;
        end else begin
            d_addr = addr; d_we = we; d_wdata = wdata; d_req = 1'b1;
        end
        lat  = 0;
        snap = '0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 1) snap = {mem_write, mem_read, mem_instr, mem_addr};
            if (fetch ? if_ack : d_ack) break;
        end
        if_req = 1'b0;
        d_req  = 1'b0;
    endtask

    int          lat, acks, n, wc0;
    logic [15:0] snap;

    initial begin
        for (int i = 0; i < 13; i++) begin
            imem[i] = 13'h0100 + 13'(i);
            dmem[i] = '0;
        end
        reset = 1'b0; mem_en = 1'b1; model_done = 1'b0; spur_done = 1'b0;
        mem_rdata = '0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0;
        #1 check("reset_outs", 64'(all_outs), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // 1. store addr 5
        wc0 = wr_count;
        access(1'b0, 1'b1, 13'd5, 13'h0ABC, 1'b0, 13'h0000, lat, snap);
        check("store_strobes", 64'(snap), 64'({1'b1, 1'b0, 1'b0, 13'd5}));
        check("store_latency", 64'(lat), 64'd2);
        check("store_once", 64'(wr_count - wc0), 64'd1);
        check("store_mem", 64'(dmem[5]), 64'h0ABC);
        @(negedge clk);

        // 2. load back, then fetch addr 0
        access(1'b0, 1'b0, 13'd5, 13'h0, 1'b0, 13'h0ABC, lat, snap);
        check("load_strobes", 64'(snap), 64'({1'b0, 1'b1, 1'b0, 13'd5}));
        @(negedge clk);
        access(1'b1, 1'b0, 13'd0, 13'h0, 1'b0, 13'h0100, lat, snap);
        check("fetch_strobes", 64'(snap), 64'({1'b0, 1'b1, 1'b1, 13'd0}));
        check("fetch_latency", 64'(lat), 64'd2);
        @(negedge clk);

        // boundary: last valid word
        access(1'b0, 1'b1, 13'd12, 13'h1234, 1'b0, 13'h0000, lat, snap);
        @(negedge clk);
        access(1'b0, 1'b0, 13'd12, 13'h0, 1'b0, 13'h1234, lat, snap);
        @(negedge clk);

        // 3. both requesters held: D,D,D,F,D,D,D,F
        for (int k = 0; k < 8; k++)
            sb.push_back('{fetch: (k % 4 == 3), err: 1'b0,
                           rdata: (k % 4 == 3) ? 13'h0102 : 13'h0ABC});
        d_we = 1'b0; d_addr = 13'd5; if_addr = 13'd2;
        d_req = 1'b1; if_req = 1'b1;
        acks = 0; n = 0;
        while (acks < 8 && n < 200) begin
            @(negedge clk);
            n++;
            if (if_ack || d_ack) acks++;
        end
        d_req = 1'b0; if_req = 1'b0;
        check("stream_acks", 64'(acks), 64'd8);
        @(negedge clk);

        // 4. out-of-range data and fetch
        access(1'b0, 1'b0, 13'd13, 13'h0, 1'b1, 13'h0000, lat, snap);
        check("oor_no_strobe", 64'(snap[15:14]), 64'd0);
        check("oor_latency", 64'(lat), 64'd1);
        @(negedge clk);
        access(1'b1, 1'b0, 13'd20, 13'h0, 1'b1, 13'h0000, lat, snap);
        check("oor_fetch_latency", 64'(lat), 64'd1);
        @(negedge clk);

        // mem_done while idle is ignored
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        check("idle_done_busy", 64'(busy), 64'd0);
        @(negedge clk);

        // 5. timeout
        mem_en = 1'b0;
        access(1'b0, 1'b0, 13'd7, 13'h0, 1'b1, 13'h0000, lat, snap);
        check("timeout_read", 64'(snap[14]), 64'd1);
        check("timeout_latency", 64'(lat), 64'd16);
        check("timeout_strobes_off", 64'({mem_read, mem_write}), 64'd0);
        check("timeout_busy", 64'(busy), 64'd0);
        @(negedge clk);

        // 6. reset mid-WAIT drops the access
        d_addr = 13'd3; d_we = 1'b0; d_req = 1'b1;
        repeat (3) @(negedge clk);
        check("pre_reset_busy", 64'(busy), 64'd1);
        #2 reset = 1'b0;
        #1 check("async_reset_outs", 64'(all_outs), 64'd0);
        d_req = 1'b0;
        mem_en = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);

        // normal operation after reset
        access(1'b1, 1'b0, 13'd12, 13'h0, 1'b0, 13'h010C, lat, snap);
        repeat (3) @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
